iq_dispatch: RTL and testbench
==============================

Name: iq_dispatch

Overview:
- Parametrised successor to the single-issue instruction queue.
- Circular buffer of DEPTH decoded control words between decode and the reservation stations.
- Dispatches the head entry to a branch RS or one of NUM_RS general RSs, chosen by round-robin instead of fixed priority.
- Adds a synchronous flush, an occupancy count, and optional stall counters.

Parameters:
DEPTH, 8, number of queue entries; power of two, ≥2
DATA_W, 96, opaque control-word payload width
NUM_RS, 4, general reservation-station count, ≥1

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush (mispredict); clears queue
enq_valid_i  in  1  decode presents an entry
enq_ready_o  out  1  queue can accept (= !full)
enq_data_i  in  DATA_W  control word
enq_is_br_i  in  1  entry is a branch
enq_wr_rd_i  in  1  entry writes a destination register
rob_full_i  in  1  ROB cannot allocate
rs_empty_i  in  NUM_RS  per-RS free flag
br_empty_i  in  1  branch RS free
rs_load_o  out  NUM_RS  one-hot RS load
br_load_o  out  1  branch RS load
rob_load_o  out  1  ROB allocate (= dispatch fire)
regfile_allocate_o  out  1  rename rd at dispatch
head_data_o  out  DATA_W  head control word; zero when empty
count_o  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Async reset (reset_n_i=0) clears head/tail pointers, count=0, rr_ptr=0, all valid bits and stall counters. Outputs during reset: enq_ready_o=0 and all load outputs 0.
- Storage is registered. An entry enqueued in cycle N can dispatch no earlier than cycle N+1; there is no empty bypass.
- Enqueue fires when enq_valid_i & enq_ready_o & !flush_i. It writes at tail and tail wraps modulo DEPTH.
- enq_ready_o = (count < DEPTH) & reset_n_i. When full, a same-cycle dequeue does not open a slot (unless the optional feature is compiled in).
- Dispatch is evaluated only when count>0, !rob_full_i and !flush_i:
  - Head is a branch: fire iff br_empty_i; assert br_load_o.
  - Head is not a branch: fire iff |rs_empty_i. rs_load_o is one-hot on the first free RS scanning upward from rr_ptr with wrap. On fire, rr_ptr <= granted index + 1 mod NUM_RS.
- On fire, also: rob_load_o=1, head advances with wrap, count decrements.
- regfile_allocate_o = fire & !is_br & wr_rd.
- No fire: all load outputs are 0 and head_data_o still shows the head entry.
- Simultaneous enqueue and fire: count unchanged and both pointers advance.
- Flush has priority over everything. In the flush cycle: no enqueue, no dispatch, all loads 0. Next cycle: count=0, head=tail=0. rr_ptr is preserved.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. The full/empty decision uses count, not pointer equality.
- All load outputs are combinational from registered state plus rob_full_i, rs_empty_i, br_empty_i and flush_i. There is no combinational path from enq_* to any output.

Optional Feature:
- Macro IQ_STALL_CNT_EN.
- When defined, adds two outputs, stall_rob_o[31:0] and stall_rs_o[31:0], both saturating at 32'hFFFFFFFF and reset to 0 (flush does not clear them).
  - stall_rob_o increments each cycle with count>0 & rob_full_i & !flush_i.
  - stall_rs_o increments each cycle with count>0 & !rob_full_i & !flush_i & no fire.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Fill DEPTH=8 with rs_empty_i=0: count_o reaches 8 and enq_ready_o=0. Enqueue attempt 9 is dropped. Then rs_empty_i=4'b1111 drains one entry per cycle in FIFO order over 8 cycles, with rs_load_o sequence 0001,0010,0100,1000,0001,...
- Round-robin: rr_ptr=2 and rs_empty_i=4'b1011 gives rs_load_o=4'b1000, then rr_ptr=0.
- Branch head with br_empty_i=0 and rs_empty_i=4'b1111: no fire and rob_load_o=0. Setting br_empty_i=1 gives br_load_o=1, regfile_allocate_o=0.
- rob_full_i=1 with 3 entries queued: no loads for 5 cycles and count_o stays 3. With IQ_STALL_CNT_EN, stall_rob_o=5.
- flush_i pulses with 5 entries while enq_valid_i=1: loads are 0 that cycle. Next cycle count_o=0 and head_data_o=0.
- Wrap-around: 20 alternating enqueue/fire cycles at count=1, entries carry payload values 1..20. Dispatched values arrive as 1..20 in order. Assert reset_n_i mid-stream: outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iq_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : iq_dispatch
//  Purpose  : Circular instruction queue between decode and the reservation
//             stations. The head entry goes to the branch RS, or to one of
//             NUM_RS general RSs picked by round-robin. The block also has a
//             synchronous flush and an occupancy count.
//  Options  : IQ_STALL_CNT_EN adds the saturating stall counters
//             stall_rob_o and stall_rs_o.
//  Revision : 1.0 - initial release
// ============================================================================
module iq_dispatch #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 96,
   parameter int NUM_RS = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   output logic                       enq_ready_o,
   input  logic [DATA_W-1:0]          enq_data_i,
   input  logic                       enq_is_br_i,
   input  logic                       enq_wr_rd_i,
   input  logic                       rob_full_i,
   input  logic [NUM_RS-1:0]          rs_empty_i,
   input  logic                       br_empty_i,
   output logic [NUM_RS-1:0]          rs_load_o,
   output logic                       br_load_o,
   output logic                       rob_load_o,
   output logic                       regfile_allocate_o,
   output logic [DATA_W-1:0]          head_data_o,
`ifdef IQ_STALL_CNT_EN
   output logic [31:0]                stall_rob_o,
   output logic [31:0]                stall_rs_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH+1);
   localparam int c_rs_w  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [DEPTH-1:0]   r_is_br;
   logic [DEPTH-1:0]   r_wr_rd;
   logic [DEPTH-1:0]   r_valid;
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_cnt_w-1:0] r_count;
   logic [c_rs_w-1:0]  r_rr_ptr;

   logic               w_enq_fire;
   logic               w_eval;
   logic               w_head_br;
   logic               w_head_wr;
   logic               w_fire;
   logic               w_rs_found;
   logic [c_rs_w-1:0]  w_rs_grant;
   logic [c_rs_w-1:0]  w_rr_next;
   logic [NUM_RS-1:0]  w_rs_onehot;
   int                 w_scan;

   // The ready signal depends only on occupancy and reset. A slot freed by a
   // same-cycle dispatch is not offered back to decode.
   assign enq_ready_o = (r_count < c_cnt_w'(DEPTH)) & reset_n_i;
   assign w_enq_fire  = enq_valid_i & enq_ready_o & ~flush_i;

   assign w_head_br = r_is_br[r_head];
   assign w_head_wr = r_wr_rd[r_head];
   assign w_eval    = (r_count != '0) & ~rob_full_i & ~flush_i;
   assign w_fire    = w_eval & (w_head_br ? br_empty_i : w_rs_found);

   // Round-robin search: first free general RS at or above r_rr_ptr, with wrap
   always_comb begin
      w_rs_found  = 1'b0;
      w_rs_grant  = '0;
      w_scan      = 0;
      w_rs_onehot = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         w_scan = int'(r_rr_ptr) + i;
         if (w_scan >= NUM_RS) begin
            w_scan = w_scan - NUM_RS;
         end
         if (!w_rs_found && rs_empty_i[w_scan]) begin
            w_rs_found = 1'b1;
            w_rs_grant = c_rs_w'(w_scan);
         end
      end
      w_rs_onehot[w_rs_grant] = w_rs_found;
   end

   assign w_rr_next = (w_rs_grant == c_rs_w'(NUM_RS-1)) ? '0 : w_rs_grant + c_rs_w'(1);

   assign br_load_o          = w_fire & w_head_br;
   assign rs_load_o          = (w_fire & ~w_head_br) ? w_rs_onehot : '0;
   assign rob_load_o         = w_fire;
   assign regfile_allocate_o = w_fire & ~w_head_br & w_head_wr;
   assign head_data_o        = r_valid[r_head] ? r_mem[r_head] : '0;
   assign count_o            = r_count;

   // Payload storage: written at the tail on enqueue. It needs no reset
   // because the valid bits guard every read.
   always_ff @(posedge clk_i) begin
      if (w_enq_fire) begin
         r_mem[r_tail]   <= enq_data_i;
         r_is_br[r_tail] <= enq_is_br_i;
         r_wr_rd[r_tail] <= enq_wr_rd_i;
      end
   end

   // Pointers, occupancy, valid bits and round-robin pointer. Flush empties
   // the queue but keeps the round-robin position.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_rr_ptr <= '0;
         r_valid  <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_fire) begin
            r_head          <= r_head + c_ptr_w'(1);
            r_valid[r_head] <= 1'b0;
         end
         if (w_fire & ~w_head_br) begin
            r_rr_ptr <= w_rr_next;
         end
         if (w_enq_fire) begin
            r_tail          <= r_tail + c_ptr_w'(1);
            r_valid[r_tail] <= 1'b1;
         end
         case ({w_enq_fire, w_fire})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef IQ_STALL_CNT_EN
   logic [31:0] r_stall_rob;
   logic [31:0] r_stall_rs;

   // Saturating stall counters. They are cleared only by reset, not by flush.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_stall_rob <= '0;
         r_stall_rs  <= '0;
      end else begin
         if ((r_count != '0) && rob_full_i && !flush_i && (r_stall_rob != 32'hFFFF_FFFF)) begin
            r_stall_rob <= r_stall_rob + 32'd1;
         end
         if (w_eval && !w_fire && (r_stall_rs != 32'hFFFF_FFFF)) begin
            r_stall_rs <= r_stall_rs + 32'd1;
         end
      end
   end

   assign stall_rob_o = r_stall_rob;
   assign stall_rs_o  = r_stall_rs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iq_dispatch
//  Purpose  : Self-checking bench for iq_dispatch. It uses a vector table,
//             directed corner-case sequences and random traffic, all checked
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iq_dispatch;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 96;
   localparam int NUM_RS = 4;
   localparam int CW     = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              enq_valid;
   logic              enq_ready;
   logic [DATA_W-1:0] enq_data;
   logic              enq_is_br;
   logic              enq_wr_rd;
   logic              rob_full;
   logic [NUM_RS-1:0] rs_empty;
   logic              br_empty;
   logic [NUM_RS-1:0] rs_load;
   logic              br_load;
   logic              rob_load;
   logic              regfile_allocate;
   logic [DATA_W-1:0] head_data;
   logic [CW-1:0]     count;
`ifdef IQ_STALL_CNT_EN
   logic [31:0]       stall_rob;
   logic [31:0]       stall_rs;
`endif

   iq_dispatch #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_RS(NUM_RS)) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n),
      .flush_i            (flush),
      .enq_valid_i        (enq_valid),
      .enq_ready_o        (enq_ready),
      .enq_data_i         (enq_data),
      .enq_is_br_i        (enq_is_br),
      .enq_wr_rd_i        (enq_wr_rd),
      .rob_full_i         (rob_full),
      .rs_empty_i         (rs_empty),
      .br_empty_i         (br_empty),
      .rs_load_o          (rs_load),
      .br_load_o          (br_load),
      .rob_load_o         (rob_load),
      .regfile_allocate_o (regfile_allocate),
      .head_data_o        (head_data),
`ifdef IQ_STALL_CNT_EN
      .stall_rob_o        (stall_rob),
      .stall_rs_o         (stall_rs),
`endif
      .count_o            (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              is_br;
      logic              wr_rd;
   } ent_t;

   ent_t        mq[$];
   int          m_rr;
   int          m_grant;
   logic        m_fire;
   logic        m_ready;
   logic [31:0] ms_rob;
   logic [31:0] ms_rs;

   typedef struct packed {
      logic              enq_valid;
      logic [DATA_W-1:0] data;
      logic [NUM_RS-1:0] rs_empty;
      logic [NUM_RS-1:0] exp_rs_load;
      logic              exp_rob;
      logic [CW-1:0]     exp_count;
      logic              exp_ready;
      logic [DATA_W-1:0] exp_head;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rr   = 0;
      ms_rob = '0;
      ms_rs  = '0;
   endtask

   task automatic drive(input logic ev, input logic [DATA_W-1:0] d, input logic br,
                        input logic wr, input logic rf, input logic [NUM_RS-1:0] rse,
                        input logic bre, input logic fl);
      enq_valid = ev;
      enq_data  = d;
      enq_is_br = br;
      enq_wr_rd = wr;
      rob_full  = rf;
      rs_empty  = rse;
      br_empty  = bre;
      flush     = fl;
      #1;
   endtask

   // Compute this cycle's expected outputs from the queue contents and compare
   task automatic model_check();
      ent_t              h;
      logic [NUM_RS-1:0] e_rs;
      logic              e_br;
      logic              e_ralloc;
      logic [DATA_W-1:0] e_head;
      h       = '0;
      m_fire  = 1'b0;
      m_grant = -1;
      e_rs    = '0;
      e_br    = 1'b0;
      e_head  = '0;
      m_ready = (mq.size() < DEPTH);
      if (mq.size() > 0) begin
         h      = mq[0];
         e_head = h.data;
         if (!rob_full && !flush) begin
            if (h.is_br) begin
               m_fire = br_empty;
               e_br   = br_empty;
            end else begin
               for (int i = 0; i < NUM_RS; i++) begin
                  int j;
                  j = (m_rr + i) % NUM_RS;
                  if (m_grant < 0 && rs_empty[j]) m_grant = j;
               end
               if (m_grant >= 0) begin
                  m_fire        = 1'b1;
                  e_rs[m_grant] = 1'b1;
               end
            end
         end
      end
      e_ralloc = m_fire && !h.is_br && h.wr_rd;
      chk("m_count",  128'(count),            128'(mq.size()));
      chk("m_ready",  128'(enq_ready),        128'(m_ready));
      chk("m_rsload", 128'(rs_load),          128'(e_rs));
      chk("m_brload", 128'(br_load),          128'(e_br));
      chk("m_robld",  128'(rob_load),         128'(m_fire));
      chk("m_ralloc", 128'(regfile_allocate), 128'(e_ralloc));
      chk("m_head",   128'(head_data),        128'(e_head));
`ifdef IQ_STALL_CNT_EN
      chk("m_stall_rob", 128'(stall_rob), 128'(ms_rob));
      chk("m_stall_rs",  128'(stall_rs),  128'(ms_rs));
`endif
   endtask

   // Advance the model across one clock edge using the inputs held at that edge
   task automatic model_update();
      ent_t e;
      if (mq.size() > 0 && !flush) begin
         if (rob_full) begin
            if (ms_rob != 32'hFFFF_FFFF) ms_rob = ms_rob + 1;
         end else if (!m_fire) begin
            if (ms_rs != 32'hFFFF_FFFF) ms_rs = ms_rs + 1;
         end
      end
      if (flush) begin
         mq.delete();
      end else begin
         if (m_fire) begin
            e = mq.pop_front();
            if (m_grant >= 0) m_rr = (m_grant + 1) % NUM_RS;
         end
         if (enq_valid && m_ready) begin
            e.data  = enq_data;
            e.is_br = enq_is_br;
            e.wr_rd = enq_wr_rd;
            mq.push_back(e);
         end
      end
   endtask

   task automatic tick();
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rob_base;
      rob_base = '0;
      reset_n  = 1'b0;
      drive(1'b1, 96'h5, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
      #1;
      chk("rst_ready",  128'(enq_ready), 128'(0));
      chk("rst_count",  128'(count),     128'(0));
      chk("rst_rsload", 128'(rs_load),   128'(0));
      chk("rst_robld",  128'(rob_load),  128'(0));
      chk("rst_brload", 128'(br_load),   128'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();

      // Table: fill to DEPTH with no free RS, drop the ninth entry, then drain
      for (int k = 0; k < 9; k++) begin
         vecs[k].enq_valid   = 1'b1;
         vecs[k].data        = DATA_W'(k + 1);
         vecs[k].rs_empty    = '0;
         vecs[k].exp_rs_load = '0;
         vecs[k].exp_rob     = 1'b0;
         vecs[k].exp_count   = CW'(k);
         vecs[k].exp_ready   = (k < 8);
         vecs[k].exp_head    = (k == 0) ? '0 : DATA_W'(1);
      end
      for (int j = 0; j < 8; j++) begin
         vecs[9+j].enq_valid   = 1'b0;
         vecs[9+j].data        = '0;
         vecs[9+j].rs_empty    = 4'hF;
         vecs[9+j].exp_rs_load = NUM_RS'(1 << (j % 4));
         vecs[9+j].exp_rob     = 1'b1;
         vecs[9+j].exp_count   = CW'(8 - j);
         vecs[9+j].exp_ready   = (j != 0);
         vecs[9+j].exp_head    = DATA_W'(j + 1);
      end
      for (int r = 0; r < 17; r++) begin
         drive(vecs[r].enq_valid, vecs[r].data, 1'b0, 1'b1, 1'b0, vecs[r].rs_empty, 1'b0, 1'b0);
         chk("tbl_rsload", 128'(rs_load),   128'(vecs[r].exp_rs_load));
         chk("tbl_robld",  128'(rob_load),  128'(vecs[r].exp_rob));
         chk("tbl_count",  128'(count),     128'(vecs[r].exp_count));
         chk("tbl_ready",  128'(enq_ready), 128'(vecs[r].exp_ready));
         chk("tbl_head",   128'(head_data), 128'(vecs[r].exp_head));
         tick();
      end
      chk("drain_count", 128'(count), 128'(0));

      // Round-robin: move the pointer to 2, then grant past a busy RS
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, DATA_W'(100 + k), 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
      chk("rr_g0", 128'(rs_load), 128'(4'b0001));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
      chk("rr_g1", 128'(rs_load), 128'(4'b0010));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0);
      chk("rr_skip", 128'(rs_load), 128'(4'b1000));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
      chk("rr_wrap", 128'(rs_load), 128'(4'b0001));
      tick();

      // Branch head waits for the branch RS even when general RSs are free
      drive(1'b1, DATA_W'(200), 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
      chk("br_wait_rob", 128'(rob_load), 128'(0));
      chk("br_wait_rs",  128'(rs_load),  128'(0));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
      chk("br_load",   128'(br_load),          128'(1));
      chk("br_ralloc", 128'(regfile_allocate), 128'(0));
      chk("br_rob",    128'(rob_load),         128'(1));
      tick();

      // ROB full with three entries queued: five stalled cycles
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, DATA_W'(250 + k), 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
         tick();
      end
`ifdef IQ_STALL_CNT_EN
      rob_base = stall_rob;
`endif
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
         chk("robfull_load",  128'(rob_load), 128'(0));
         chk("robfull_count", 128'(count),    128'(3));
         tick();
      end
`ifdef IQ_STALL_CNT_EN
      chk("stall_rob_delta", 128'(stall_rob - rob_base), 128'(5));
`endif

      // Flush with five entries while decode keeps presenting
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, DATA_W'(260 + k), 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, DATA_W'(300), 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1);
      chk("flush_count_pre", 128'(count),    128'(5));
      chk("flush_rob",       128'(rob_load), 128'(0));
      chk("flush_rs",        128'(rs_load),  128'(0));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("flush_count", 128'(count),     128'(0));
      chk("flush_head",  128'(head_data), 128'(0));
      tick();

      // Wrap-around: payloads 1..20 enqueued and dispatched at occupancy 1
      drive(1'b1, DATA_W'(1), 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
      chk("wrap_first_rob", 128'(rob_load), 128'(0));
      tick();
      for (int k = 2; k <= 21; k++) begin
         drive((k <= 20), DATA_W'(k), 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
         chk("wrap_rob",   128'(rob_load),  128'(1));
         chk("wrap_data",  128'(head_data), 128'(k - 1));
         chk("wrap_count", 128'(count),     128'(1));
         tick();
      end

      // Asynchronous reset while a dispatch is pending
      drive(1'b1, DATA_W'(55), 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
      chk("prerst_rob", 128'(rob_load), 128'(1));
      reset_n = 1'b0;
      #1;
      chk("arst_rob",   128'(rob_load),  128'(0));
      chk("arst_rs",    128'(rs_load),   128'(0));
      chk("arst_count", 128'(count),     128'(0));
      chk("arst_ready", 128'(enq_ready), 128'(0));
      chk("arst_head",  128'(head_data), 128'(0));
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(($urandom % 3) != 0, {$urandom, $urandom, $urandom}, ($urandom % 4) == 0,
               1'($urandom % 2), ($urandom % 4) == 0, NUM_RS'($urandom), 1'($urandom % 2),
               ($urandom % 32) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
